// File: rtl/plru_ctrl_if.sv
// Request/response bus between a cache requester and the pseudo-LRU controller.
interface plru_ctrl_if #(
  parameter int S_INDEX = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [S_INDEX-1:0] req_set;
  logic               req_hit;
  logic [1:0]         req_way;
  logic               rsp_valid;
  logic [1:0]         rsp_way;

  modport master (
    output req_valid, req_set, req_hit, req_way,
    input  req_ready, rsp_valid, rsp_way
  );

  modport slave (
    input  req_valid, req_set, req_hit, req_way,
    output req_ready, rsp_valid, rsp_way
  );
endinterface

// File: rtl/plru_ctrl.sv
// Pseudo-LRU replacement controller for a 4-way cache. Reads a set's 3-bit
// tree on port 0, writes the updated tree back on port 1 one cycle later,
// and sweeps all trees to zero on flush.
module plru_ctrl #(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst,
  plru_ctrl_if.slave         bus,
  input  logic               flush,
  output logic               busy,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  input  logic [2:0]         lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [2:0]         lru_din1,
  input  logic [2:0]         lru_dout1
);

  typedef enum logic {RUN = 1'b0, SWEEP = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [S_INDEX-1:0] sweep_idx;
  logic               accept;
  logic               vld_p1;
  logic [S_INDEX-1:0] set_p1;
  logic               hit_p1;
  logic [1:0]         way_p1;
  logic [1:0]         touch_way_p1;
  logic [2:0]         tree_new_p1;
  logic               unused_dout1;

  // Victim: b0 picks the half, b1/b2 pick the way inside that half.
  function automatic logic [1:0] victim_way(input logic [2:0] tree);
    victim_way = tree[0] ? {1'b1, tree[2]} : {1'b0, tree[1]};
  endfunction

  // Point every tree bit on the path to way w away from w; keep the other leaf bit.
  function automatic logic [2:0] tree_update(input logic [2:0] tree, input logic [1:0] w);
    logic [2:0] t;
    t    = tree;
    t[0] = ~w[1];
    if (w[1]) t[2] = ~w[0];
    else      t[1] = ~w[0];
    tree_update = t;
  endfunction

  assign unused_dout1  = ^lru_dout1;
  assign bus.req_ready = (state_q == RUN) && !flush;
  assign accept        = bus.req_valid && bus.req_ready;

  // ---- S0: accept cycle, read the set's tree on port 0 ----
  assign lru_csb0  = !accept;
  assign lru_web0  = 1'b1;
  assign lru_addr0 = bus.req_set;

  // S1 valid is control and is cleared by reset; an in-flight op is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  // S1 request fields are data only and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      set_p1 <= bus.req_set;
      hit_p1 <= bus.req_hit;
      way_p1 <= bus.req_way;
    end
  end

  // ---- S1: tree arrives on lru_dout0, compute victim and new tree ----
  assign touch_way_p1  = hit_p1 ? way_p1 : victim_way(lru_dout0);
  assign tree_new_p1   = tree_update(lru_dout0, touch_way_p1);
  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_way   = touch_way_p1;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state: flush starts a sweep that ends after the last set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = SWEEP;
      SWEEP:   if (&sweep_idx) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Sweep counter advances every SWEEP cycle and wraps back to 0 on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sweep_idx <= '0;
    else if (state_q == SWEEP) sweep_idx <= sweep_idx + S_INDEX'(1);
  end

  // FSM outputs: port 1 carries the sweep clear or the S1 write-back.
  always_comb begin
    busy      = 1'b0;
    lru_csb1  = 1'b1;
    lru_web1  = 1'b1;
    lru_addr1 = set_p1;
    lru_din1  = tree_new_p1;
    if (state_q == SWEEP) begin
      busy      = 1'b1;
      lru_csb1  = 1'b0;
      lru_web1  = 1'b0;
      lru_addr1 = sweep_idx;
      lru_din1  = 3'b000;
    end else if (vld_p1) begin
      lru_csb1  = 1'b0;
      lru_web1  = 1'b0;
    end
  end

endmodule
